// File: rtl/vga_io_pkg.sv
// Shared constants and types for the VGA I/O controller: port map,
// CRTC register indices, reset values and the palette writer state type.
package vga_io_pkg;

   localparam logic [15:0] PORT_DAC_WIDX  = 16'h03C8;
   localparam logic [15:0] PORT_DAC_DATA  = 16'h03C9;
   localparam logic [15:0] PORT_CRTC_IDX  = 16'h03D4;
   localparam logic [15:0] PORT_CRTC_DATA = 16'h03D5;
   localparam logic [15:0] PORT_MODE      = 16'h03D8;
   localparam logic [15:0] PORT_STATUS    = 16'h03DA;

   localparam logic [7:0] CRTC_CUR_START = 8'h0A;
   localparam logic [7:0] CRTC_CUR_END   = 8'h0B;
   localparam logic [7:0] CRTC_CUR_HI    = 8'h0E;
   localparam logic [7:0] CRTC_CUR_LO    = 8'h0F;

   localparam logic [10:0] RST_CURSOR    = 11'd0;
   localparam logic [5:0]  RST_SHAPE_LO  = 6'd14;
   localparam logic [4:0]  RST_SHAPE_HI  = 5'd15;
   localparam logic [1:0]  RST_MODE      = 2'd0;
   localparam logic [7:0]  RST_CRTC_IDX  = 8'h00;
   localparam logic [7:0]  RST_DAC_IDX   = 8'h00;
   localparam logic [7:0]  RST_PORT_O    = 8'h00;
   localparam logic [7:0]  UNDECODED_RD  = 8'hFF;

   typedef enum logic [1:0] {
      S_R = 2'd0,
      S_G = 2'd1,
      S_B = 2'd2
   } dac_state_e;

   // 6-bit DAC component to 8 bits by replicating the top bits into the LSBs.
   function automatic logic [7:0] expand6(input logic [5:0] c);
      return {c, c[5:4]};
   endfunction

endpackage

// File: rtl/vga_dac_writer.sv
// Palette writer: collects R,G,B components written to the DAC data port
// and emits one registered write pulse per completed triplet.
//
// state | meaning
// S_R   | waiting for red component
// S_G   | red latched, waiting for green
// S_B   | red+green latched, next data write completes the entry
module vga_dac_writer
   import vga_io_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        idx_we_i,
   input  logic        data_we_i,
   input  logic [7:0]  wdata_i,
   output logic [7:0]  index_o,
   output logic        dac_we_o,
   output logic [7:0]  dac_address_o,
   output logic [31:0] dac_data_o
);

   dac_state_e  state_q, state_d;
   logic [5:0]  red_q, red_d;
   logic [5:0]  grn_q, grn_d;
   logic [7:0]  index_q, index_d;
   logic        we_q, we_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] data_q, data_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_R;
         red_q   <= 6'd0;
         grn_q   <= 6'd0;
         index_q <= RST_DAC_IDX;
         we_q    <= 1'b0;
         addr_q  <= 8'h00;
         data_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         red_q   <= red_d;
         grn_q   <= grn_d;
         index_q <= index_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // An index load always restarts the triplet; an in-flight pulse is
   // already registered and completes untouched.
   always_comb begin
      state_d = state_q;
      red_d   = red_q;
      grn_d   = grn_q;
      index_d = index_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      if (idx_we_i) begin
         index_d = wdata_i;
         state_d = S_R;
      end else if (data_we_i) begin
         case (state_q)
            S_R: begin
               red_d   = wdata_i[5:0];
               state_d = S_G;
            end
            S_G: begin
               grn_d   = wdata_i[5:0];
               state_d = S_B;
            end
            S_B: begin
               we_d    = 1'b1;
               addr_d  = index_q;
               data_d  = {8'h00, expand6(red_q), expand6(grn_q), expand6(wdata_i[5:0])};
               index_d = index_q + 8'd1;
               state_d = S_R;
            end
            default: state_d = S_R;
         endcase
      end
   end

   assign index_o       = index_q;
   assign dac_we_o      = we_q;
   assign dac_address_o = addr_q;
   assign dac_data_o    = data_q;

endmodule

// File: rtl/vga_ioctl.sv
// CPU-facing VGA I/O block: port decode, CRTC cursor registers, mode
// register and registered readback; palette writes go to vga_dac_writer.
module vga_ioctl
   import vga_io_pkg::*;
(
   input  logic        clock_25,
   input  logic        reset,
   input  logic [15:0] port_a,
   input  logic [7:0]  port_i,
   input  logic        port_w,
   input  logic        port_r,
   input  logic        retrace,
   output logic [7:0]  port_o,
   output logic [10:0] cursor,
   output logic [5:0]  cursor_shape_lo,
   output logic [4:0]  cursor_shape_hi,
   output logic [1:0]  videomode,
   output logic        dac_we,
   output logic [7:0]  dac_address,
   output logic [31:0] dac_data
);

   logic [7:0]  crtc_idx_q, crtc_idx_d;
   logic [10:0] cursor_q, cursor_d;
   logic [5:0]  shape_lo_q, shape_lo_d;
   logic [4:0]  shape_hi_q, shape_hi_d;
   logic [1:0]  mode_q, mode_d;
   logic [7:0]  port_o_q, port_o_d;
   logic [7:0]  rd_data;
   logic [7:0]  dac_index;
   logic        dac_idx_we;
   logic        dac_data_we;

   assign dac_idx_we  = port_w && (port_a == PORT_DAC_WIDX);
   assign dac_data_we = port_w && (port_a == PORT_DAC_DATA);

   vga_dac_writer u_dac_writer (
      .clk_i         (clock_25),
      .rst_i         (reset),
      .idx_we_i      (dac_idx_we),
      .data_we_i     (dac_data_we),
      .wdata_i       (port_i),
      .index_o       (dac_index),
      .dac_we_o      (dac_we),
      .dac_address_o (dac_address),
      .dac_data_o    (dac_data)
   );

   always_ff @(posedge clock_25) begin
      if (reset) begin
         crtc_idx_q <= RST_CRTC_IDX;
         cursor_q   <= RST_CURSOR;
         shape_lo_q <= RST_SHAPE_LO;
         shape_hi_q <= RST_SHAPE_HI;
         mode_q     <= RST_MODE;
         port_o_q   <= RST_PORT_O;
      end else begin
         crtc_idx_q <= crtc_idx_d;
         cursor_q   <= cursor_d;
         shape_lo_q <= shape_lo_d;
         shape_hi_q <= shape_hi_d;
         mode_q     <= mode_d;
         port_o_q   <= port_o_d;
      end
   end

   always_comb begin
      crtc_idx_d = crtc_idx_q;
      cursor_d   = cursor_q;
      shape_lo_d = shape_lo_q;
      shape_hi_d = shape_hi_q;
      mode_d     = mode_q;
      if (port_w) begin
         case (port_a)
            PORT_CRTC_IDX: crtc_idx_d = port_i;
            PORT_CRTC_DATA: begin
               case (crtc_idx_q)
                  CRTC_CUR_START: shape_lo_d = port_i[5:0];
                  CRTC_CUR_END:   shape_hi_d = port_i[4:0];
                  CRTC_CUR_HI:    cursor_d[10:8] = port_i[2:0];
                  CRTC_CUR_LO:    cursor_d[7:0]  = port_i;
                  default: ;
               endcase
            end
            PORT_MODE: mode_d = port_i[1:0];
            default: ;
         endcase
      end
   end

   // Readback uses register values before this cycle's write.
   always_comb begin
      rd_data = UNDECODED_RD;
      case (port_a)
         PORT_CRTC_IDX: rd_data = crtc_idx_q;
         PORT_CRTC_DATA: begin
            case (crtc_idx_q)
               CRTC_CUR_START: rd_data = {2'b00, shape_lo_q};
               CRTC_CUR_END:   rd_data = {3'b000, shape_hi_q};
               CRTC_CUR_HI:    rd_data = {5'b00000, cursor_q[10:8]};
               CRTC_CUR_LO:    rd_data = cursor_q[7:0];
               default:        rd_data = 8'h00;
            endcase
         end
         PORT_MODE:     rd_data = {6'b000000, mode_q};
         PORT_STATUS:   rd_data = {4'b0000, retrace, 2'b00, retrace};
         PORT_DAC_WIDX: rd_data = dac_index;
         PORT_DAC_DATA: rd_data = 8'h00;
         default:       rd_data = UNDECODED_RD;
      endcase
   end

   assign port_o_d = port_r ? rd_data : port_o_q;

   assign port_o          = port_o_q;
   assign cursor          = cursor_q;
   assign cursor_shape_lo = shape_lo_q;
   assign cursor_shape_hi = shape_hi_q;
   assign videomode       = mode_q;

endmodule

// File: tb/tb_vga_ioctl.sv
// Directed bench for vga_ioctl: CRTC, mode/status, palette triplets,
// index reload and reset behaviour against hand-computed values.
module tb_vga_ioctl;

   logic        clock_25;
   logic        reset;
   logic [15:0] port_a;
   logic [7:0]  port_i;
   logic        port_w;
   logic        port_r;
   logic        retrace;
   logic [7:0]  port_o;
   logic [10:0] cursor;
   logic [5:0]  cursor_shape_lo;
   logic [4:0]  cursor_shape_hi;
   logic [1:0]  videomode;
   logic        dac_we;
   logic [7:0]  dac_address;
   logic [31:0] dac_data;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          we_total = 0;
   logic [7:0]  we_addr  = 8'h00;
   logic [31:0] we_data  = 32'h0;

   vga_ioctl dut (
      .clock_25        (clock_25),
      .reset           (reset),
      .port_a          (port_a),
      .port_i          (port_i),
      .port_w          (port_w),
      .port_r          (port_r),
      .retrace         (retrace),
      .port_o          (port_o),
      .cursor          (cursor),
      .cursor_shape_lo (cursor_shape_lo),
      .cursor_shape_hi (cursor_shape_hi),
      .videomode       (videomode),
      .dac_we          (dac_we),
      .dac_address     (dac_address),
      .dac_data        (dac_data)
   );

   initial clock_25 = 1'b0;
   always #5 clock_25 = ~clock_25;

   // Every cycle with dac_we high is counted and its payload captured.
   always @(posedge clock_25) begin
      if (dac_we) begin
         we_total <= we_total + 1;
         we_addr  <= dac_address;
         we_data  <= dac_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic io_write(input logic [15:0] a, input logic [7:0] d);
      port_a = a;
      port_i = d;
      port_w = 1'b1;
      @(negedge clock_25);
      port_w = 1'b0;
   endtask

   task automatic io_read(input logic [15:0] a, output logic [7:0] d);
      port_a = a;
      port_r = 1'b1;
      @(negedge clock_25);
      port_r = 1'b0;
      d = port_o;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clock_25);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clock_25);
      reset = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".cursor"},   {21'h0, cursor}, 32'd0);
      check({tag, ".shape_lo"}, {26'h0, cursor_shape_lo}, 32'd14);
      check({tag, ".shape_hi"}, {27'h0, cursor_shape_hi}, 32'd15);
      check({tag, ".mode"},     {30'h0, videomode}, 32'd0);
      check({tag, ".dac_we"},   {31'h0, dac_we}, 32'd0);
      check({tag, ".dac_addr"}, {24'h0, dac_address}, 32'd0);
      check({tag, ".dac_data"}, dac_data, 32'd0);
      check({tag, ".port_o"},   {24'h0, port_o}, 32'd0);
   endtask

   initial begin
      logic [7:0] rd;
      int         we_base;

      reset   = 1'b1;
      port_a  = 16'h0000;
      port_i  = 8'h00;
      port_w  = 1'b0;
      port_r  = 1'b0;
      retrace = 1'b0;
      idle(3);
      reset = 1'b0;
      check_reset_state("rst");
      io_read(16'h03D4, rd);  check("rst.crtc_idx", {24'h0, rd}, 32'h00);
      io_read(16'h03C8, rd);  check("rst.dac_idx",  {24'h0, rd}, 32'h00);

      // CRTC cursor position and shape
      io_write(16'h03D4, 8'h0E);
      io_write(16'h03D5, 8'h07);
      check("crtc.cur_hi", {21'h0, cursor}, 32'h700);
      io_write(16'h03D4, 8'h0F);
      io_write(16'h03D5, 8'hCF);
      check("crtc.cursor", {21'h0, cursor}, 32'h7CF);
      io_read(16'h03D5, rd);  check("crtc.rd_lo", {24'h0, rd}, 32'hCF);
      idle(2);
      check("crtc.rd_hold", {24'h0, port_o}, 32'hCF);
      io_write(16'h03D4, 8'h0E);
      io_read(16'h03D5, rd);  check("crtc.rd_hi", {24'h0, rd}, 32'h07);
      io_write(16'h03D4, 8'h0A);
      io_write(16'h03D5, 8'hFF);
      check("crtc.shape_lo", {26'h0, cursor_shape_lo}, 32'h3F);
      io_write(16'h03D4, 8'h0B);
      io_write(16'h03D5, 8'hFF);
      check("crtc.shape_hi", {27'h0, cursor_shape_hi}, 32'h1F);
      io_read(16'h03D5, rd);  check("crtc.rd_shape_hi", {24'h0, rd}, 32'h1F);
      io_write(16'h03D4, 8'h20);
      io_write(16'h03D5, 8'h55);
      check("crtc.unk_wr", {21'h0, cursor}, 32'h7CF);
      io_read(16'h03D5, rd);  check("crtc.unk_rd", {24'h0, rd}, 32'h00);
      io_read(16'h03D4, rd);  check("crtc.rd_idx", {24'h0, rd}, 32'h20);

      // DAC triplet and next-index targeting
      we_base = we_total;
      io_write(16'h03C8, 8'h10);
      io_write(16'h03C9, 8'h3F);
      io_write(16'h03C9, 8'h00);
      io_write(16'h03C9, 8'h20);
      check("dac1.we_high", {31'h0, dac_we}, 32'd1);
      idle(2);
      check("dac1.count", we_total - we_base, 1);
      check("dac1.addr", {24'h0, we_addr}, 32'h10);
      check("dac1.data", we_data, 32'h00FF0082);
      check("dac1.addr_hold", {24'h0, dac_address}, 32'h10);
      io_read(16'h03C8, rd);  check("dac1.next_idx", {24'h0, rd}, 32'h11);
      io_write(16'h03C9, 8'h01);
      io_write(16'h03C9, 8'h02);
      io_write(16'h03C9, 8'h03);
      idle(2);
      check("dac2.count", we_total - we_base, 2);
      check("dac2.addr", {24'h0, we_addr}, 32'h11);
      check("dac2.data", we_data, 32'h0004080C);

      // Index wrap FFh -> 00h
      we_base = we_total;
      io_write(16'h03C8, 8'hFF);
      io_write(16'h03C9, 8'h3F);
      io_write(16'h03C9, 8'h3F);
      io_write(16'h03C9, 8'h3F);
      idle(2);
      check("wrap.addr", {24'h0, we_addr}, 32'hFF);
      check("wrap.data", we_data, 32'h00FFFFFF);
      io_read(16'h03C8, rd);  check("wrap.idx", {24'h0, rd}, 32'h00);
      io_write(16'h03C9, 8'h10);
      io_write(16'h03C9, 8'h20);
      io_write(16'h03C9, 8'h30);
      idle(2);
      check("wrap.count", we_total - we_base, 2);
      check("wrap.addr0", {24'h0, we_addr}, 32'h00);
      check("wrap.data0", we_data, 32'h004182C3);

      // Partial triplet discarded by index reload
      we_base = we_total;
      io_write(16'h03C8, 8'h05);
      io_write(16'h03C9, 8'h11);
      io_write(16'h03C9, 8'h22);
      io_write(16'h03C8, 8'h09);
      idle(2);
      check("part.none", we_total - we_base, 0);
      io_write(16'h03C9, 8'h0A);
      io_write(16'h03C9, 8'h15);
      io_write(16'h03C9, 8'h2A);
      idle(2);
      check("part.count", we_total - we_base, 1);
      check("part.addr", {24'h0, we_addr}, 32'h09);
      check("part.data", we_data, 32'h002855AA);

      // Index reload in the same cycle as the pending pulse
      we_base = we_total;
      io_write(16'h03C8, 8'h20);
      io_write(16'h03C9, 8'h01);
      io_write(16'h03C9, 8'h01);
      io_write(16'h03C9, 8'h01);
      io_write(16'h03C8, 8'h30);
      idle(2);
      check("coin.count", we_total - we_base, 1);
      check("coin.addr", {24'h0, we_addr}, 32'h20);
      check("coin.data", we_data, 32'h00040404);
      io_read(16'h03C8, rd);  check("coin.idx", {24'h0, rd}, 32'h30);
      io_write(16'h03C9, 8'h00);
      io_write(16'h03C9, 8'h00);
      io_write(16'h03C9, 8'h01);
      idle(2);
      check("coin.addr2", {24'h0, we_addr}, 32'h30);
      check("coin.data2", we_data, 32'h00000004);

      // Mode register, status, undecoded ports, read-during-write
      io_write(16'h03D8, 8'hFF);
      check("mode.three", {30'h0, videomode}, 32'd3);
      io_write(16'h03D8, 8'h02);
      check("mode.two", {30'h0, videomode}, 32'd2);
      retrace = 1'b1;
      io_read(16'h03DA, rd);  check("stat.retrace1", {24'h0, rd}, 32'h09);
      retrace = 1'b0;
      io_read(16'h03DA, rd);  check("stat.retrace0", {24'h0, rd}, 32'h00);
      io_read(16'h1234, rd);  check("undec.rd", {24'h0, rd}, 32'hFF);
      io_read(16'h13D8, rd);  check("undec.rd_hi", {24'h0, rd}, 32'hFF);
      io_write(16'h13D8, 8'h01);
      check("undec.wr", {30'h0, videomode}, 32'd2);
      io_read(16'h03C9, rd);  check("dacdata.rd", {24'h0, rd}, 32'h00);
      port_r = 1'b1;
      io_write(16'h03D8, 8'h00);
      port_r = 1'b0;
      check("rw.read_old", {24'h0, port_o}, 32'h02);
      check("rw.mode_new", {30'h0, videomode}, 32'd0);

      // Reset mid-triplet
      io_write(16'h03D4, 8'h0F);
      io_write(16'h03D5, 8'h12);
      io_read(16'h03D5, rd);
      we_base = we_total;
      io_write(16'h03C8, 8'h40);
      io_write(16'h03C9, 8'h3F);
      io_write(16'h03C9, 8'h3F);
      pulse_reset();
      check_reset_state("midrst");
      io_write(16'h03C9, 8'h3F);
      idle(3);
      check("midrst.no_we", we_total - we_base, 0);
      io_write(16'h03C9, 8'h00);
      io_write(16'h03C9, 8'h3F);
      idle(2);
      check("midrst.count", we_total - we_base, 1);
      check("midrst.addr", {24'h0, we_addr}, 32'h00);
      check("midrst.data", we_data, 32'h00FF00FF);

      // Reset landing in the dac_we cycle cancels the pulse's follow-up state
      io_write(16'h03C8, 8'h50);
      io_write(16'h03C9, 8'h01);
      io_write(16'h03C9, 8'h01);
      io_write(16'h03C9, 8'h01);
      we_base = we_total;
      pulse_reset();
      idle(2);
      check_reset_state("werst");
      check("werst.after", we_total - we_base, 1);
      io_read(16'h03C8, rd);  check("werst.idx", {24'h0, rd}, 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
